// File: rtl/exmem_io_ctrl.sv
// Switch/button front end for an external word-addressed RAM: address entry, single writes, timed reads.
// Optional build macro EXMEM_AUTO_INC_EN makes the address step by one after every completed write.
module exmem_io_ctrl #(
    parameter int RD_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  io_state,
    input  logic [15:0] sw,
    input  logic        btn_c,
    output logic [7:0]  mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_we,
    output logic        mem_re,
    input  logic [31:0] mem_rdata,
    input  logic        mem_rvalid,
    output logic [31:0] display,
    output logic        busy,
    output logic        err
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WRITE   = 2'd1,
        WAIT_RD = 2'd2
    } state_t;

    // Last counter value before a read is declared lost; the mem_re cycle counts as zero.
    localparam logic [7:0] RD_LAST = 8'(RD_TIMEOUT - 1);

    state_t      state, state_next;
    logic        btn_c_q;
    logic        press;
    logic [7:0]  addr_reg;
    logic        addr_valid;
    logic [7:0]  rd_cnt;

    logic do_addr, do_write, do_werr, do_read;
    logic wr_done, rd_done, rd_timeout, rd_wait, err_clr;

    assign press    = btn_c & ~btn_c_q;
    assign busy     = (state != IDLE);
    assign mem_addr = addr_reg;

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        do_addr    = 1'b0;
        do_write   = 1'b0;
        do_werr    = 1'b0;
        do_read    = 1'b0;
        wr_done    = 1'b0;
        rd_done    = 1'b0;
        rd_timeout = 1'b0;
        rd_wait    = 1'b0;
        err_clr    = 1'b0;
        case (state)
            IDLE: begin
                err_clr = (io_state == 2'd0);
                if (press) begin
                    case (io_state)
                        2'd1: do_addr = 1'b1;
                        2'd2: begin
                            do_read    = 1'b1;
                            state_next = WAIT_RD;
                        end
                        2'd3: begin
                            if (addr_valid) begin
                                do_write   = 1'b1;
                                state_next = WRITE;
                            end else begin
                                do_werr = 1'b1;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            WRITE: begin
                wr_done    = 1'b1;
                state_next = IDLE;
            end
            WAIT_RD: begin
                // Data arriving on the final allowed cycle beats the timeout.
                if (mem_rvalid) begin
                    rd_done    = 1'b1;
                    state_next = IDLE;
                end else if (rd_cnt == RD_LAST) begin
                    rd_timeout = 1'b1;
                    state_next = IDLE;
                end else begin
                    rd_wait = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Registered strobes, address/data holding registers and display.
    always_ff @(posedge clk) begin
        if (reset) begin
            btn_c_q    <= 1'b0;
            addr_reg   <= 8'd0;
            addr_valid <= 1'b0;
            rd_cnt     <= 8'd0;
            mem_we     <= 1'b0;
            mem_re     <= 1'b0;
            mem_wdata  <= 32'd0;
            display    <= 32'd0;
            err        <= 1'b0;
        end else begin
            btn_c_q <= btn_c;
            mem_we  <= 1'b0;
            mem_re  <= 1'b0;
            if (err_clr)
                err <= 1'b0;
            if (do_werr || rd_timeout)
                err <= 1'b1;
            if (do_addr || do_read) begin
                addr_reg   <= sw[7:0];
                addr_valid <= 1'b1;
            end
            if (do_addr)
                display <= {24'b0, sw[7:0]};
            if (do_read) begin
                mem_re <= 1'b1;
                rd_cnt <= 8'd0;
            end
            if (rd_wait)
                rd_cnt <= rd_cnt + 8'd1;
            if (rd_done)
                display <= mem_rdata;
            if (do_write) begin
                mem_we    <= 1'b1;
                mem_wdata <= {16'b0, sw};
            end
            if (wr_done) begin
                display <= mem_wdata;
`ifdef EXMEM_AUTO_INC_EN
                addr_reg <= addr_reg + 8'd1;
`else
                addr_reg <= addr_reg;
`endif
            end
        end
    end

endmodule

// File: tb/tb_exmem_io_ctrl.sv
// Directed bench for exmem_io_ctrl: address entry, writes, reads, timeout race, held button, reset mid-read.
module tb_exmem_io_ctrl;

    localparam int RD_TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  io_state;
    logic [15:0] sw;
    logic        btn_c;
    logic [7:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_we;
    logic        mem_re;
    logic [31:0] mem_rdata;
    logic        mem_rvalid;
    logic [31:0] display;
    logic        busy;
    logic        err;

    int checks = 0;
    int errors = 0;
    int we_cnt = 0;
    int re_cnt = 0;
    int overlap_cnt = 0;
    int re_base;
    int we_base;

    exmem_io_ctrl #(.RD_TIMEOUT(RD_TIMEOUT)) dut (
        .clk(clk), .reset(reset), .io_state(io_state), .sw(sw), .btn_c(btn_c),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re),
        .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid), .display(display),
        .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (mem_we) we_cnt++;
        if (mem_re) re_cnt++;
        if (mem_we && mem_re) overlap_cnt++;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [7:0] exp_addr;
        reset = 1'b1; io_state = 2'd0; sw = 16'd0; btn_c = 1'b0;
        mem_rdata = 32'd0; mem_rvalid = 1'b0;
        tick; tick;
        reset = 1'b0;
        tick;
        check("rst_display", display, 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_we_re", {30'd0, mem_we, mem_re}, 32'd0);
        check("rst_addr", {24'd0, mem_addr}, 32'd0);
        check("rst_wdata", mem_wdata, 32'd0);

        // Data press with no address entered
        io_state = 2'd3; sw = 16'h1234; btn_c = 1'b1;
        tick;
        btn_c = 1'b0;
        tick;
        check("noaddr_err", {31'd0, err}, 32'd1);
        check("noaddr_we", we_cnt, 0);
        io_state = 2'd0;
        tick;
        check("err_clear", {31'd0, err}, 32'd0);

        // Address 5, write BEEF
        io_state = 2'd1; sw = 16'h0005; btn_c = 1'b1;
        tick;
        btn_c = 1'b0;
        tick;
        check("addr_display", display, 32'h0000_0005);
        check("addr_reg", {24'd0, mem_addr}, 32'h05);
        io_state = 2'd3; sw = 16'hBEEF; btn_c = 1'b1;
        we_base = we_cnt;
        tick;
        check("wr_we", {31'd0, mem_we}, 32'd1);
        check("wr_addr", {24'd0, mem_addr}, 32'h05);
        check("wr_wdata", mem_wdata, 32'h0000_BEEF);
        check("wr_busy", {31'd0, busy}, 32'd1);
        btn_c = 1'b0; io_state = 2'd0;
        tick;
        check("wr_we_off", {31'd0, mem_we}, 32'd0);
        check("wr_display", display, 32'h0000_BEEF);
        check("wr_idle", {31'd0, busy}, 32'd0);
        check("wr_pulses", we_cnt - we_base, 1);
`ifdef EXMEM_AUTO_INC_EN
        exp_addr = 8'h06;
`else
        exp_addr = 8'h05;
`endif
        check("wr_addr_after", {24'd0, mem_addr}, {24'd0, exp_addr});

        // Read address 5, RAM answers 3 cycles after mem_re; io_state wanders meanwhile
        io_state = 2'd2; sw = 16'h0005; btn_c = 1'b1;
        re_base = re_cnt;
        tick;
        check("rd_re", {31'd0, mem_re}, 32'd1);
        check("rd_addr", {24'd0, mem_addr}, 32'h05);
        btn_c = 1'b0; io_state = 2'd1;
        tick; tick; tick;
        check("rd_busy_wait", {31'd0, busy}, 32'd1);
        check("rd_display_hold", display, 32'h0000_BEEF);
        mem_rvalid = 1'b1; mem_rdata = 32'hDEAD_BEEF;
        tick;
        mem_rvalid = 1'b0;
        check("rd_display", display, 32'hDEAD_BEEF);
        check("rd_idle", {31'd0, busy}, 32'd0);
        check("rd_pulses", re_cnt - re_base, 1);

        // Silent RAM with the button held 20 cycles
        io_state = 2'd2; sw = 16'h0022; btn_c = 1'b1;
        re_base = re_cnt;
        tick;
        for (int i = 1; i < RD_TIMEOUT; i++) tick;
        check("to_err_early", {31'd0, err}, 32'd0);
        check("to_busy_early", {31'd0, busy}, 32'd1);
        tick;
        check("to_err", {31'd0, err}, 32'd1);
        check("to_idle", {31'd0, busy}, 32'd0);
        check("to_display", display, 32'hDEAD_BEEF);
        for (int i = RD_TIMEOUT + 1; i < 20; i++) tick;
        btn_c = 1'b0;
        tick;
        check("held_one_re", re_cnt - re_base, 1);
        io_state = 2'd0;
        tick;
        check("to_err_clear", {31'd0, err}, 32'd0);

        // Data on the last allowed cycle beats the timeout
        io_state = 2'd2; sw = 16'h0033; btn_c = 1'b1;
        tick;
        btn_c = 1'b0;
        for (int i = 1; i < RD_TIMEOUT; i++) tick;
        check("race_busy", {31'd0, busy}, 32'd1);
        mem_rvalid = 1'b1; mem_rdata = 32'hCAFE_F00D;
        tick;
        mem_rvalid = 1'b0;
        check("race_display", display, 32'hCAFE_F00D);
        check("race_err", {31'd0, err}, 32'd0);
        check("race_idle", {31'd0, busy}, 32'd0);

        // Stray rvalid in IDLE
        mem_rvalid = 1'b1; mem_rdata = 32'h0000_0099;
        tick;
        mem_rvalid = 1'b0;
        tick;
        check("idle_rvalid", display, 32'hCAFE_F00D);

        // Two writes starting at 0xFF
        io_state = 2'd1; sw = 16'h00FF; btn_c = 1'b1;
        tick;
        btn_c = 1'b0;
        tick;
        io_state = 2'd3; sw = 16'h0A01; btn_c = 1'b1;
        tick;
        check("inc_we1", {31'd0, mem_we}, 32'd1);
        check("inc_addr1", {24'd0, mem_addr}, 32'hFF);
        btn_c = 1'b0;
        tick;
        sw = 16'h0A02; btn_c = 1'b1;
        tick;
`ifdef EXMEM_AUTO_INC_EN
        exp_addr = 8'h00;
`else
        exp_addr = 8'hFF;
`endif
        check("inc_we2", {31'd0, mem_we}, 32'd1);
        check("inc_addr2", {24'd0, mem_addr}, {24'd0, exp_addr});
        check("inc_wdata2", mem_wdata, 32'h0000_0A02);
        btn_c = 1'b0;
        tick;

        // Reset in the middle of a read
        io_state = 2'd2; sw = 16'h0044; btn_c = 1'b1;
        tick;
        btn_c = 1'b0;
        tick;
        check("mid_busy", {31'd0, busy}, 32'd1);
        reset = 1'b1;
        tick;
        reset = 1'b0;
        mem_rvalid = 1'b1; mem_rdata = 32'h1111_1111;
        tick;
        mem_rvalid = 1'b0;
        tick;
        check("mid_display", display, 32'd0);
        check("mid_err", {31'd0, err}, 32'd0);
        check("mid_idle", {31'd0, busy}, 32'd0);
        check("mid_addr", {24'd0, mem_addr}, 32'd0);

        check("we_re_overlap", overlap_cnt, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
